// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Multi-cycle multiply/divide unit for the EX stage. Owns the
//             HI/LO registers and drives Busy for the hazard unit. The result
//             of the latched operation is committed on the edge where the
//             cycle counter reaches zero.
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDOp,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  count;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic        is_md;
    logic        load;
    logic        finish;
    logic        op_is_div;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] divu_q;
    logic [31:0] divu_r;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign is_md     = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                       (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
    assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);

    // Busy is simply the registered RUN state.
    assign Busy = (state == ST_RUN);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode: issue from IDLE, complete when count is 1.
    always_comb begin
        state_next = state;
        Start      = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_md) begin
                    Start      = 1'b1;
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (count == 4'd1) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Signed division is done on magnitudes so INT_MIN / -1 wraps to
    // 0x80000000 with remainder 0 without any special case.
    always_comb begin
        prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
        prod_u = {32'd0, op_a} * {32'd0, op_b};
        a_neg  = op_a[31];
        b_neg  = op_b[31];
        a_mag  = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag  = b_neg ? (~op_b + 32'd1) : op_b;
        q_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
        r_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
        div_q  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        div_r  = a_neg ? (~r_mag + 32'd1) : r_mag;
        divu_q = (op_b == 32'd0) ? 32'd0 : (op_a / op_b);
        divu_r = (op_b == 32'd0) ? 32'd0 : (op_a % op_b);
    end

    // Result select for the latched operation.
    always_comb begin
        res_hi = hi_reg;
        res_lo = lo_reg;
        case (op)
            OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OP_DIV:   begin res_hi = div_r;         res_lo = div_q;        end
            OP_DIVU:  begin res_hi = divu_r;        res_lo = divu_q;       end
            default:  begin res_hi = hi_reg;        res_lo = lo_reg;       end
        endcase
    end

    // Operand latch, cycle counter and HI/LO updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 4'd0;
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            op     <= OP_NONE;
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (load) begin
            op_a  <= A;
            op_b  <= B;
            op    <= MDOp;
            count <= ((MDOp == OP_DIV) || (MDOp == OP_DIVU)) ? DIV_LOAD : MULT_LOAD;
        end else if (state == ST_RUN) begin
            count <= count - 4'd1;
            // A zero divisor still costs the full latency but leaves HI/LO alone.
            if (finish && !(op_is_div && (op_b == 32'd0))) begin
                hi_reg <= res_hi;
                lo_reg <= res_lo;
            end
        end else if (MDOp == OP_MTHI) begin
            hi_reg <= A;
        end else if (MDOp == OP_MTLO) begin
            lo_reg <= A;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Scoreboard bench for mult_div_unit with directed and random ops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t scoreboard[$];

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    int   mon_cnt  = 0;
    logic mon_prev = 1'b0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: returns {HI,LO} after the operation.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint          sa, sbv, q, r;
        longint unsigned ua, ub;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (o)
            3'd1: return 64'(sa * sbv);
            3'd2: return 64'(ua * ub);
            3'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            3'd5: return {a, lo};
            3'd6: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    // Monitor: counts Busy cycles and checks HI/LO whenever an operation completes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_cnt  = 0;
                mon_prev = 1'b0;
            end else begin
                if (Busy) begin
                    mon_cnt++;
                end else if (mon_prev) begin
                    if (scoreboard.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got completion expected none");
                    end else begin
                        e = scoreboard.pop_front();
                        chk("busy_cycles", 32'(mon_cnt), 32'(e.cycles));
                        chk("hi_result", HI, e.hi);
                        chk("lo_result", LO, e.lo);
                    end
                    mon_cnt = 0;
                end
                mon_prev = Busy;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (Busy && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (Busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy expected idle");
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit junk);
        logic [63:0] r;
        int          n;
        bit          md;
        @(posedge clk);
        #1;
        A    = a;
        B    = b;
        MDOp = o;
        md   = (o >= 3'd1) && (o <= 3'd4);
        n    = (o <= 3'd2) ? 5 : 10;
        #1;
        chk("start", {31'd0, Start}, {31'd0, md});
        r    = ref_op(o, a, b, m_hi, m_lo);
        m_hi = r[63:32];
        m_lo = r[31:0];
        if (md) scoreboard.push_back('{r[63:32], r[31:0], n});
        @(posedge clk);
        #1;
        if (md) begin
            chk("busy_after_issue", {31'd0, Busy}, 32'd1);
            chk("start_while_busy", {31'd0, Start}, 32'd0);
            if (junk) begin
                for (int k = 0; k < n - 1; k++) begin
                    A    = $urandom;
                    B    = $urandom;
                    MDOp = 3'($urandom_range(0, 7));
                    @(posedge clk);
                    #1;
                end
            end
            MDOp = 3'd0;
            wait_idle();
        end else begin
            MDOp = 3'd0;
            chk("busy_idle_op", {31'd0, Busy}, 32'd0);
            chk("hi_idle_op", HI, m_hi);
            chk("lo_idle_op", LO, m_lo);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        A     = 32'd0;
        B     = 32'd0;
        MDOp  = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_start", {31'd0, Start}, 32'd0);

        // Abort a divide with reset while its counter sits at 4.
        @(posedge clk);
        #1;
        A    = 32'd100;
        B    = 32'd3;
        MDOp = 3'd3;
        @(posedge clk);
        #1;
        MDOp = 3'd0;
        repeat (6) @(posedge clk);
        #1;
        chk("busy_before_abort", {31'd0, Busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        chk("abort_busy_later", {31'd0, Busy}, 32'd0);

        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFE);
        do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi", HI, 32'h0000_0001);
        chk("multu_lo", LO, 32'hFFFF_FFFE);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        do_op(3'd4, 32'd7, 32'd2, 1'b0);
        chk("divu_hi", HI, 32'd1);
        chk("divu_lo", LO, 32'd3);
        do_op(3'd5, 32'h11, 32'd0, 1'b0);
        do_op(3'd6, 32'h22, 32'd0, 1'b0);
        do_op(3'd4, 32'd7, 32'd0, 1'b0);
        chk("divzero_hi", HI, 32'h11);
        chk("divzero_lo", LO, 32'h22);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_hi", HI, 32'd0);
        chk("ovf_lo", LO, 32'h8000_0000);
        do_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        do_op(3'd6, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_hi", HI, 32'hDEAD_BEEF);
        chk("mtlo_lo", LO, 32'h1234_5678);
        do_op(3'd1, 32'd3, 32'hFFFF_FFFB, 1'b1);
        chk("ignore_hi", HI, 32'hFFFF_FFFF);
        chk("ignore_lo", LO, 32'hFFFF_FFF1);

        for (int i = 0; i < 80; i++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(scoreboard.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit sitting in the EX stage beside the ALU.
- Owns the HI/LO registers and produces the Busy signal that the pipeline hazard unit consumes to stall MD-class instructions in D. It is the producer of that stall.
- Executes mult, multu, div, divu, mthi and mtlo. HI/LO are read combinationally for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (1..15).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- A  input  32  operand rs (already forwarded in E).
- B  input  32  operand rt (already forwarded in E).
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- Start  output  1  combinational; high when MDOp is in 1..4 and Busy is 0.
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset (async): HI=0, LO=0, Busy=0, counter=0, latched operands and op=0. Reset mid-operation aborts it; no HI/LO update follows.
- Idle state (Busy=0):
  - MDOp 1..4 sampled at edge t: latch A, B and op; load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from t+1.
  - MDOp 5: HI<=A at the edge. MDOp 6: LO<=A at the edge. Busy stays 0.
- Run state (Busy=1):
  - Counter decrements each edge.
  - On the edge where counter goes 1->0: commit the result to HI/LO and set Busy=0, on that same edge.
  - Total: Busy is high for exactly N cycles after the issue edge; new HI/LO are visible in the first cycle Busy is low.
- Any MDOp arriving while Busy=1 is ignored, including mthi/mtlo and a new start. The hazard unit stalls D on (Start | Busy) for MD-class instructions, so this case does not occur in legal operation, but RTL must still ignore it.
- Arithmetic:
  - mult: {HI,LO} = signed(A) * signed(B), full 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient to LO, remainder to HI.
  - Divide by zero (B==0) for div/divu: full Busy latency elapses, HI/LO unchanged.
  - Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- Operands come from the latches, never the live A/B, so forwarding changes during Run have no effect.
- Issue on the same edge that Busy falls is impossible, because Start requires Busy=0. The earliest back-to-back issue is the cycle after completion.
- HI/LO outputs hold their old values during Run; mfhi/mflo reads during Run are prevented by the hazard stall.

Test Plan:
- Reset then idle -> HI=0, LO=0, Busy=0, Start=0. Assert reset mid-div at counter=4 -> Busy=0 immediately, HI/LO keep their pre-operation value 0.
- mult with A=0xFFFFFFFF, B=2 -> Start=1 for one cycle; Busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div with A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 -> LO=3, HI=1.
- divu with A=7, B=0 and HI/LO preloaded to 0x11/0x22 -> Busy high for 10 cycles; HI=0x11, LO=0x22 afterwards.
- mthi with A=0xDEADBEEF, then mtlo with A=0x12345678 in consecutive cycles -> HI=0xDEADBEEF, LO=0x12345678; Busy stays 0.
- Start mult, then drive MDOp=5 and MDOp=3 during Busy and change A/B -> both ignored; HI/LO show only the original product; Busy still falls after exactly 5 cycles.
